// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// opcode values, state encoding and datapath select encodings.
package mc_pkg;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LI    = 6'b100111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Controller states; the encoding is visible on state_o for debug
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMRD    = 4'd4,
    MEMWB    = 4'd5,
    MEMWR    = 4'd6,
    RTYPE_EX = 4'd7,
    ADDI_EX  = 4'd8,
    ALU_WB   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    ERROR    = 4'd12
  } state_t;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ASB_RT      = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // State following DECODE for a given opcode; unknown opcodes trap
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:      return RTYPE_EX;
      OP_ADDI, OP_LI: return ADDI_EX;
      OP_LW, OP_SW:  return MEMADR;
      OP_BEQ:        return BRANCH;
      OP_J:          return JUMP;
      default:       return ERROR;
    endcase
  endfunction

  // States that hold the memory port and wait for mem_ready
  function automatic logic is_mem_wait(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts consecutive stalled cycles and flags when
// the count has reached TIMEOUT.
module mc_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt_reg;

  // Clear has priority; the count saturates at TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != CNT_W'(TIMEOUT))) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = (cnt_reg == CNT_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath. Sequences fetch,
// decode, execute, memory and writeback; traps on illegal opcodes and on
// memory wait timeouts. Datapath controls are decoded from the state.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  state_t state_reg;
  logic   dst_reg;
  logic   illegal_reg;
  logic   bus_err_reg;

  logic   waiting;
  logic   timer_clr;
  logic   timer_inc;
  logic   timer_expired;
  logic   timeout;

  // Counter runs only while a memory state is stalled; leaving those
  // states or any completed access resets it, so every entry starts at 0
  assign waiting   = is_mem_wait(state_reg);
  assign timer_clr = mem_ready || !waiting;
  assign timer_inc = waiting && !mem_ready;
  assign timeout   = timer_inc && timer_expired;

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  // State sequencing, writeback destination capture and sticky trap flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      dst_reg     <= 1'b0;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: state_reg <= FETCH;
        FETCH: begin
          if (mem_ready) begin
            state_reg <= DECODE;
          end else if (timeout) begin
            state_reg   <= ERROR;
            bus_err_reg <= 1'b1;
          end
        end
        DECODE: begin
          state_reg <= decode_next(opcode);
          if (decode_next(opcode) == ERROR) illegal_reg <= 1'b1;
        end
        MEMADR: state_reg <= (opcode == OP_LW) ? MEMRD : MEMWR;
        MEMRD: begin
          if (mem_ready) begin
            state_reg <= MEMWB;
          end else if (timeout) begin
            state_reg   <= ERROR;
            bus_err_reg <= 1'b1;
          end
        end
        MEMWB: state_reg <= FETCH;
        MEMWR: begin
          if (mem_ready) begin
            state_reg <= FETCH;
          end else if (timeout) begin
            state_reg   <= ERROR;
            bus_err_reg <= 1'b1;
          end
        end
        RTYPE_EX: begin
          dst_reg   <= 1'b1;
          state_reg <= ALU_WB;
        end
        ADDI_EX: begin
          dst_reg   <= 1'b0;
          state_reg <= ALU_WB;
        end
        ALU_WB, BRANCH, JUMP: state_reg <= FETCH;
        ERROR:   state_reg <= ERROR;
        default: state_reg <= ERROR;
      endcase
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = ASB_RT;
    alu_op     = ALU_ADD;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = ASB_IMM_SH2;
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = dst_reg;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = zero;
      end
      JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_reg;
  assign bus_err    = bus_err_reg;
  assign state_o    = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver walks each instruction
// through its phase list, pushing the expected per-cycle state and
// control word; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 15;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5,
                         S_MEMWR = 4'd6, S_RTYPE = 4'd7, S_ADDI = 4'd8,
                         S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                         S_ERROR = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000,
                         OP_LI = 6'b100111, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010, OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       iord, mem_read, mem_write, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_dst, reg_write, mem_to_reg, illegal_op, bus_err;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;
  int n_cyc = 0;
  logic ill_m = 1'b0;
  logic be_m  = 1'b0;
  logic [20:0] sb_q[$];

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .bus_err(bus_err),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control word for a state, from the per-state output table
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr,
                                           input logic z, input logic dst);
    logic io, mrd, mwr, irw, pcw, asa, rd, rw, m2r;
    logic [1:0] ps, asb, aop;
    {io, mrd, mwr, irw, pcw, asa, rd, rw, m2r} = '0;
    ps = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin io = 1; mrd = 1; end
      S_MEMWB:  begin m2r = 1; rw = 1; end
      S_MEMWR:  begin io = 1; mwr = 1; end
      S_RTYPE:  begin asa = 1; aop = 2'b10; end
      S_ADDI:   begin asa = 1; asb = 2'b10; end
      S_ALUWB:  begin rw = 1; rd = dst; end
      S_BRANCH: begin asa = 1; aop = 2'b01; ps = 2'b01; pcw = z; end
      S_JUMP:   begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {io, mrd, mwr, irw, pcw, ps, asa, asb, aop, rd, rw, m2r, ill_m, be_m};
  endfunction

  // One clock of stimulus with its expected response queued
  task automatic step(input logic [3:0] st, input logic mr, input logic z, input logic dst);
    mem_ready = mr;
    zero      = z;
    sb_q.push_back({st, exp_ctrl(st, mr, z, dst)});
    n_cyc++;
    @(posedge clk);
    #1;
  endtask

  // Memory wait: w stalled cycles then ready; a stall that survives the
  // cycle where TIMEOUT stalls have already elapsed traps the controller
  task automatic wait_phase(input logic [3:0] st, input int w, output bit err);
    err = 1'b0;
    for (int i = 0; i <= TIMEOUT; i++) begin
      if (i == w) begin
        step(st, 1'b1, rb(), 1'b0);
        return;
      end
      step(st, 1'b0, rb(), 1'b0);
    end
    be_m = 1'b1;
    err  = 1'b1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    ill_m = 1'b0;
    be_m  = 1'b0;
    step(S_IDLE, rb(), rb(), 1'b0);
    step(S_IDLE, rb(), rb(), 1'b0);
    rst_n = 1'b1;
    step(S_IDLE, rb(), rb(), 1'b0);
  endtask

  task automatic error_and_reset(input int hold);
    repeat (hold) step(S_ERROR, rb(), rb(), 1'b0);
    reset_pulse();
  endtask

  task automatic do_instr(input logic [5:0] op, input logic z, input int wf,
                          input int wm, input int hold);
    bit err;
    int c0;
    c0 = n_cyc;
    opcode = op;
    wait_phase(S_FETCH, wf, err);
    if (!err) begin
      step(S_DECODE, rb(), rb(), 1'b0);
      case (op)
        OP_R: begin
          step(S_RTYPE, rb(), rb(), 1'b0);
          step(S_ALUWB, rb(), rb(), 1'b1);
        end
        OP_ADDI, OP_LI: begin
          step(S_ADDI, rb(), rb(), 1'b0);
          step(S_ALUWB, rb(), rb(), 1'b0);
        end
        OP_LW: begin
          step(S_MEMADR, rb(), rb(), 1'b0);
          wait_phase(S_MEMRD, wm, err);
          if (!err) step(S_MEMWB, rb(), rb(), 1'b0);
        end
        OP_SW: begin
          step(S_MEMADR, rb(), rb(), 1'b0);
          wait_phase(S_MEMWR, wm, err);
        end
        OP_BEQ: step(S_BRANCH, rb(), z, 1'b0);
        OP_J:   step(S_JUMP, rb(), rb(), 1'b0);
        default: begin
          ill_m = 1'b1;
          err   = 1'b1;
        end
      endcase
    end
    $display("instr op=%b zero=%b fetch_wait=%0d mem_wait=%0d cycles=%0d trap=%0d",
             op, z, wf, wm, n_cyc - c0, err);
    if (err) error_and_reset(hold);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  initial begin
    logic [20:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        exp_v = sb_q.pop_front();
        act_v = {state_o, iord, mem_read, mem_write, ir_write, pc_write, pc_src,
                 alu_src_a, alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg,
                 illegal_op, bus_err};
        total++;
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL ctrl t=%0t got state=%0d ctrl=%05h want state=%0d ctrl=%05h",
                   $time, act_v[20:17], act_v[16:0], exp_v[20:17], exp_v[16:0]);
        end
        total++;
        if (mem_read && mem_write) begin
          bad++;
          $display("FAIL strobe_mutex t=%0t got mem_read=1 mem_write=1 want not both", $time);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[8];
    logic [5:0] op;
    int wf, wm;
    ops = '{OP_R, OP_ADDI, OP_LI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_BAD};
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    step(S_IDLE, 1'b0, 1'b0, 1'b0);
    step(S_IDLE, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(S_IDLE, 1'b1, 1'b0, 1'b0);

    // Directed sequences
    do_instr(OP_R,   1'b0, 0, 0, 0);
    do_instr(OP_LW,  1'b0, 0, 3, 0);
    do_instr(OP_BEQ, 1'b1, 0, 0, 0);
    do_instr(OP_BEQ, 1'b0, 0, 0, 0);
    do_instr(OP_BAD, 1'b0, 0, 0, 20);
    do_instr(OP_R,   1'b0, TIMEOUT + 1, 0, 5);
    do_instr(OP_R,   1'b0, TIMEOUT, 0, 0);
    do_instr(OP_SW,  1'b0, 0, 0, 0);
    do_instr(OP_J,   1'b0, 0, 0, 0);
    do_instr(OP_SW,  1'b0, 0, TIMEOUT, 0);
    do_instr(OP_LW,  1'b0, 1, TIMEOUT + 1, 4);
    do_instr(OP_LI,  1'b0, 2, 0, 0);

    // Reset in the middle of a stalled load
    opcode = OP_LW;
    begin
      bit e;
      wait_phase(S_FETCH, 0, e);
    end
    step(S_DECODE, 1'b1, 1'b0, 1'b0);
    step(S_MEMADR, 1'b0, 1'b0, 1'b0);
    step(S_MEMRD, 1'b0, 1'b0, 1'b0);
    step(S_MEMRD, 1'b0, 1'b0, 1'b0);
    reset_pulse();

    // Random instruction stream
    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0 && op != OP_R) op = 6'($urandom);
      wf = ($urandom_range(0, 19) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                        : $urandom_range(0, 3);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                       : $urandom_range(0, 4);
      do_instr(op, rb(), wf, wm, $urandom_range(1, 6));
    end

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath variant, replacing single-cycle decode-only control.
- Sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Waits on a memory ready handshake and traps on illegal opcodes or memory timeout.
- Sits between the instruction register opcode field and the datapath mux/enable controls.

Parameters:
TIMEOUT, 15, max consecutive cycles a memory-access state may wait with mem_ready low before bus error
CNT_W, 4, width of wait counter; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26] of the current instruction
zero  in  1  ALU zero flag, used in BRANCH
mem_ready  in  1  memory completes the current read or write this cycle
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  load instruction register
pc_write  out  1  load PC (already qualified with zero for beq)
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target {PC[31:28],addr,00}
alu_src_a  out  1  0=PC, 1=rs register
alu_src_b  out  2  00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
alu_op  out  2  00=add, 01=sub, 10=use funct
reg_dst  out  1  1=rd, 0=rt
reg_write  out  1  register file write enable
mem_to_reg  out  1  1=MDR, 0=ALUOut
illegal_op  out  1  sticky: unknown opcode decoded
bus_err  out  1  sticky: memory wait timeout
state_o  out  4  current state encoding, debug/verification only

Behaviour:
- Reset: state=IDLE, wait counter=0, illegal_op=0, bus_err=0. In IDLE all strobes/enables=0 and all selects=0. IDLE→FETCH next cycle unconditionally.
- Outputs are decoded combinationally from the state, gated by mem_ready and zero where stated. Any output not listed for a state is 0.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 (R-type) → RTYPE_EX
  - 001000 (addi) or 100111 (li) → ADDI_EX
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - anything else → ERROR and set illegal_op
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw; opcode is held stable by the IR.
- MEMRD: iord=1, mem_read=1. Go to MEMWB on mem_ready, else stay.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Go to FETCH.
- MEMWR: iord=1, mem_write=1. Go to FETCH on mem_ready, else stay.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALU_WB with reg_dst=1 for that writeback.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ALU_WB with reg_dst=0.
  - The reg_dst choice is held in a 1-bit register captured in the EX state.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=registered value. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero. Go to FETCH.
- JUMP: pc_src=10, pc_write=1. Go to FETCH.
- ERROR: all strobes 0. Absorbing until rst_n is asserted.
- Latency with mem_ready tied high: beq/j 3 cycles; R-type/addi/li/sw 4 cycles; lw 5 cycles.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR, and on any cycle where mem_ready=1.
  - Increments each cycle in those states while mem_ready=0.
  - When the counter equals TIMEOUT with mem_ready still 0: go to ERROR, set bus_err, deassert strobes from the next cycle.
  - mem_ready=1 in the same cycle the count reaches TIMEOUT wins: normal transition, no error.
- Reset mid-operation: asynchronous return to IDLE, sticky flags cleared, no further strobes issued.
- The mem_read and mem_write strobes are never asserted together.

Decomposition:
- Package mc_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LI, OP_LW, OP_SW, OP_BEQ, OP_J)
  - state enum (IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, ADDI_EX, ALU_WB, BRANCH, JUMP, ERROR), 4-bit encoding
  - alu_op, alu_src_b and pc_src encodings
- Sub-module mc_wait_timer: parameterised counter with inputs clr, inc and output expired.

Test Plan:
- Reset release, mem_ready=1, opcode=000000 → state_o IDLE, FETCH, DECODE, RTYPE_EX, ALU_WB, FETCH; reg_write=1 and reg_dst=1 only in ALU_WB; pc_write=1 only in the FETCH ready cycle.
- lw (100011) with mem_ready low 3 cycles in MEMRD → MEMRD held 4 cycles with iord=1, mem_read=1; then MEMWB with mem_to_reg=1, reg_dst=0; total 8 cycles from FETCH.
- beq (000100) with zero=1, then zero=0 → BRANCH pc_write=1 and pc_src=01 for the first, pc_write=0 for the second; both return to FETCH.
- opcode=111111 at DECODE → ERROR, illegal_op=1 held 20 cycles with all strobes 0; rst_n pulse low → illegal_op=0, state IDLE.
- mem_ready held 0 in FETCH → bus_err=1 after exactly TIMEOUT=15 wait cycles, then ERROR; repeat with mem_ready=1 on the 15th cycle → no bus_err, DECODE entered.
- sw (101011) followed by j (000010) with mem_ready=1 → mem_write=1 for one cycle in MEMWR; JUMP asserts pc_write=1 with pc_src=10; mem_read and mem_write never high together.
